dvs_aer_event_receiver: RTL and testbench

Parametrised successor of dvs_aer_receiver. It terminates the DVS camera's 4-phase AER handshake (req/ack, xsel-tagged row/column words) and synchronises the asynchronous req. It reassembles complete events (x, y, polarity) with a capture timestamp and presents them on a valid/ready stream toward the RAVENS side. Downstream stall back-pressures the camera by withholding ack.

---
 rtl/dvs_aer_event_receiver.sv | 170 +++++++++++++++++
 tb/tb_dvs_aer_event_receiver.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvs_aer_event_receiver.sv
// DVS camera AER receiver: terminates the 4-phase req/ack handshake, reassembles
// row/column words into timestamped events and presents them on a valid/ready stream.
module dvs_aer_event_receiver #(
  parameter int AER_WIDTH   = 10,
  parameter int X_WIDTH     = 9,
  parameter int Y_WIDTH     = 9,
  parameter int SYNC_STAGES = 2,
  parameter int TS_WIDTH    = 16,
  parameter int ERR_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [AER_WIDTH-1:0] aer,
  input  logic                 xsel,
  input  logic                 req,
  output logic                 ack,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic [X_WIDTH-1:0]   ev_x,
  output logic [Y_WIDTH-1:0]   ev_y,
  output logic                 ev_pol,
  output logic [TS_WIDTH-1:0]  ev_ts,
  output logic [ERR_WIDTH-1:0] err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STALL,
    S_ACK
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [TS_WIDTH-1:0]    ts_q, ts_d;
  logic                   row_valid_q, row_valid_d;
  logic [Y_WIDTH-1:0]     y_q, y_d;
  logic [X_WIDTH-1:0]     pend_x_q, pend_x_d;
  logic                   pend_pol_q, pend_pol_d;
  logic [TS_WIDTH-1:0]    pend_ts_q, pend_ts_d;
  logic [ERR_WIDTH-1:0]   err_q, err_d;
  logic                   ack_q, ack_d;
  logic                   ev_valid_q, ev_valid_d;
  logic [X_WIDTH-1:0]     ev_x_q, ev_x_d;
  logic [Y_WIDTH-1:0]     ev_y_q, ev_y_d;
  logic                   ev_pol_q, ev_pol_d;
  logic [TS_WIDTH-1:0]    ev_ts_q, ev_ts_d;

  logic               req_s;
  logic               slot_free;
  logic [Y_WIDTH-1:0] row_y;
  logic [X_WIDTH-1:0] col_x;
  logic               col_pol;

  assign req_s     = sync_q[SYNC_STAGES-1];
  assign slot_free = !ev_valid_q || ev_ready;
  assign row_y     = aer[Y_WIDTH-1:0];
  assign col_x     = aer[X_WIDTH:1];
  assign col_pol   = aer[0];

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_d     = state_q;
    sync_d      = {sync_q[SYNC_STAGES-2:0], req};
    ts_d        = ts_q + TS_WIDTH'(1);
    row_valid_d = row_valid_q;
    y_d         = y_q;
    pend_x_d    = pend_x_q;
    pend_pol_d  = pend_pol_q;
    pend_ts_d   = pend_ts_q;
    err_d       = err_q;
    ev_valid_d  = ev_valid_q && !ev_ready;
    ev_x_d      = ev_x_q;
    ev_y_d      = ev_y_q;
    ev_pol_d    = ev_pol_q;
    ev_ts_d     = ev_ts_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_s) begin
          if (!xsel) begin
            // Row words bypass the output slot so they can never be blocked.
            y_d         = row_y;
            row_valid_d = 1'b1;
            state_d     = S_ACK;
          end else if (!row_valid_q) begin
            if (err_q != '1) err_d = err_q + ERR_WIDTH'(1);
            state_d = S_ACK;
          end else begin
            pend_x_d   = col_x;
            pend_pol_d = col_pol;
            pend_ts_d  = ts_q;
            if (slot_free) begin
              ev_valid_d = 1'b1;
              ev_x_d     = col_x;
              ev_y_d     = y_q;
              ev_pol_d   = col_pol;
              ev_ts_d    = ts_q;
              state_d    = S_ACK;
            end else begin
              state_d = S_STALL;
            end
          end
        end
      end
      S_STALL: begin
        // Withholding ack here is what back-pressures the camera.
        if (slot_free) begin
          ev_valid_d = 1'b1;
          ev_x_d     = pend_x_q;
          ev_y_d     = y_q;
          ev_pol_d   = pend_pol_q;
          ev_ts_d    = pend_ts_q;
          state_d    = S_ACK;
        end
      end
      S_ACK: begin
        if (!req_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    ack_d = (state_d == S_ACK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sync_q      <= '0;
      ts_q        <= '0;
      row_valid_q <= 1'b0;
      y_q         <= '0;
      pend_x_q    <= '0;
      pend_pol_q  <= 1'b0;
      pend_ts_q   <= '0;
      err_q       <= '0;
      ack_q       <= 1'b0;
      ev_valid_q  <= 1'b0;
      ev_x_q      <= '0;
      ev_y_q      <= '0;
      ev_pol_q    <= 1'b0;
      ev_ts_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      state_q     <= state_d;
      sync_q      <= sync_d;
      ts_q        <= ts_d;
      row_valid_q <= row_valid_d;
      y_q         <= y_d;
      pend_x_q    <= pend_x_d;
      pend_pol_q  <= pend_pol_d;
      pend_ts_q   <= pend_ts_d;
      err_q       <= err_d;
      ack_q       <= ack_d;
      ev_valid_q  <= ev_valid_d;
      ev_x_q      <= ev_x_d;
      ev_y_q      <= ev_y_d;
      ev_pol_q    <= ev_pol_d;
      ev_ts_q     <= ev_ts_d;
    end
  end

  assign ack      = ack_q;
  assign ev_valid = ev_valid_q;
  assign ev_x     = ev_x_q;
  assign ev_y     = ev_y_q;
  assign ev_pol   = ev_pol_q;
  assign ev_ts    = ev_ts_q;
  assign err_cnt  = err_q;

endmodule

// File: tb/tb_dvs_aer_event_receiver.sv
// Scoreboard bench for dvs_aer_event_receiver: a camera task pushes expected events,
// a negedge monitor pops and compares on every accepted output.
module tb_dvs_aer_event_receiver;

  localparam int AW    = 10;
  localparam int XW    = 9;
  localparam int YW    = 9;
  localparam int SS    = 2;
  localparam int TW    = 16;
  localparam int EW    = 8;
  localparam int BOUND = 200;

  typedef struct {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          pol;
    logic [TW-1:0] ts;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] aer = '0;
  logic          xsel = 1'b0;
  logic          req = 1'b0;
  logic          ack;
  logic          ev_valid;
  logic          ev_ready = 1'b0;
  logic [XW-1:0] ev_x;
  logic [YW-1:0] ev_y;
  logic          ev_pol;
  logic [TW-1:0] ev_ts;
  logic [EW-1:0] err_cnt;

  int          checks = 0;
  int          errors = 0;
  ev_t         exp_q[$];
  bit          row_seen = 0;
  logic [YW-1:0] y_m = '0;
  int          err_exp = 0;
  bit          ready_cmd = 0;
  bit          rand_ready = 0;
  int unsigned cyc;

  dvs_aer_event_receiver #(
    .AER_WIDTH(AW), .X_WIDTH(XW), .Y_WIDTH(YW),
    .SYNC_STAGES(SS), .TS_WIDTH(TW), .ERR_WIDTH(EW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .aer(aer), .xsel(xsel), .req(req), .ack(ack),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_x(ev_x), .ev_y(ev_y),
    .ev_pol(ev_pol), .ev_ts(ev_ts), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Reference clock count since reset release; the capture timestamp is derived from it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(posedge clk) begin
    #1;
    ev_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_cmd;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops on each accepted event and checks that a stalled output holds steady.
  bit   hold_v = 0;
  ev_t  held;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 0;
    end else begin
      if (hold_v) begin
        check("hold_valid", 32'(ev_valid), 1);
        check("hold_x", 32'(ev_x), 32'(held.x));
        check("hold_ts", 32'(ev_ts), 32'(held.ts));
      end
      if (ev_valid && ev_ready) begin
        check("event_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          ev_t e;
          e = exp_q.pop_front();
          check("ev_x", 32'(ev_x), 32'(e.x));
          check("ev_y", 32'(ev_y), 32'(e.y));
          check("ev_pol", 32'(ev_pol), 32'(e.pol));
          check("ev_ts", 32'(ev_ts), 32'(e.ts));
        end
      end
      hold_v = ev_valid && !ev_ready;
      held.x = ev_x;
      held.y = ev_y;
      held.pol = ev_pol;
      held.ts = ev_ts;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    req = 1'b0;
    xsel = 1'b0;
    aer = '0;
    exp_q.delete();
    row_seen = 0;
    err_exp = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Camera model: one full 4-phase handshake for a row or column word.
  task automatic send(input bit is_col, input logic [XW-1:0] x, input logic [YW-1:0] y,
                      input logic pol, input bit chk_lat, input int hold);
    int  n;
    ev_t e;
    @(posedge clk); #1;
    if (is_col) begin
      aer = AW'({x, pol});
      if (row_seen) begin
        e.x = x; e.y = y_m; e.pol = pol; e.ts = TW'(cyc + SS);
        exp_q.push_back(e);
      end else if (err_exp < 255) begin
        err_exp++;
      end
    end else begin
      aer = AW'(y);
      row_seen = 1;
      y_m = y;
    end
    xsel = is_col;
    req = 1'b1;
    n = 0;
    while (!ack && n < BOUND) begin @(posedge clk); #1; n++; end
    check("ack_rise", 32'(ack), 1);
    if (chk_lat) check("ack_latency", 32'(n), SS + 1);
    repeat (hold) @(posedge clk);
    #1 req = 1'b0;
    n = 0;
    while (ack && n < BOUND) begin @(posedge clk); #1; n++; end
    check("ack_fall", 32'(ack), 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < BOUND) begin @(posedge clk); n++; end
    #1 check("drain", 32'(exp_q.size()), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    do_reset();
    check("rst_ack", 32'(ack), 0);
    check("rst_valid", 32'(ev_valid), 0);
    check("rst_data", 32'({ev_x, ev_y, ev_pol}), 0);
    check("rst_ts", 32'(ev_ts), 0);
    check("rst_err", 32'(err_cnt), 0);

    // Orphan column straight after reset.
    ready_cmd = 1;
    send(1, 9'd20, 0, 0, 1, 0);
    check("orphan_err", 32'(err_cnt), 1);
    check("orphan_noev", 32'(ev_valid), 0);

    // Basic event with latency checks.
    send(0, 0, 9'd5, 0, 1, 0);
    send(1, 9'd17, 0, 1, 1, 2);
    drain();

    // Repeated columns on the same row.
    send(0, 0, 9'd5, 0, 0, 0);
    send(1, 9'd1, 0, 0, 0, 0);
    send(1, 9'd2, 0, 1, 0, 1);
    send(1, 9'd3, 0, 0, 0, 0);
    drain();

    // Back-pressure: second column stalls until ev_ready rises.
    ready_cmd = 0;
    repeat (2) @(posedge clk);
    send(0, 0, 9'd7, 0, 0, 0);
    send(1, 9'd10, 0, 1, 0, 0);
    fork
      send(1, 9'd11, 0, 0, 0, 0);
      begin
        repeat (SS + 6) @(posedge clk);
        #1;
        check("stall_no_ack", 32'(ack), 0);
        check("stall_held_valid", 32'(ev_valid), 1);
        check("stall_held_x", 32'(ev_x), 10);
        ready_cmd = 1;
      end
    join
    drain();
    check("err_unchanged", 32'(err_cnt), 1);

    // Reset in the middle of ACK.
    @(posedge clk); #1;
    aer = AW'(9'd2); xsel = 1'b0; req = 1'b1;
    n = 0;
    while (!ack && n < BOUND) begin @(posedge clk); #1; n++; end
    check("midack_ack_high", 32'(ack), 1);
    rst_n = 1'b0;
    #1;
    check("midack_rst_ack", 32'(ack), 0);
    check("midack_rst_valid", 32'(ev_valid), 0);
    do_reset();

    // Reset in the middle of STALL.
    ready_cmd = 0;
    repeat (2) @(posedge clk);
    send(0, 0, 9'd3, 0, 0, 0);
    send(1, 9'd4, 0, 1, 0, 0);
    @(posedge clk); #1;
    aer = AW'({9'd5, 1'b0}); xsel = 1'b1; req = 1'b1;
    repeat (SS + 4) @(posedge clk);
    #1;
    check("midstall_no_ack", 32'(ack), 0);
    check("midstall_valid", 32'(ev_valid), 1);
    rst_n = 1'b0;
    #1;
    check("midstall_rst_ack", 32'(ack), 0);
    check("midstall_rst_valid", 32'(ev_valid), 0);
    do_reset();
    ready_cmd = 1;
    send(1, 9'd9, 0, 0, 0, 0);
    check("post_rst_err", 32'(err_cnt), 1);

    // Error counter saturation.
    do_reset();
    for (int i = 0; i < 300; i++) send(1, 9'(i), 0, 1'(i), 0, 0);
    check("err_sat", 32'(err_cnt), 255);

    // Randomised camera with random downstream readiness.
    do_reset();
    rand_ready = 1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0)
        send(0, 0, 9'($urandom_range(0, 511)), 0, 0, $urandom_range(0, 3));
      send(1, 9'($urandom_range(0, 511)), 0, 1'($urandom_range(0, 1)), 0, $urandom_range(0, 3));
    end
    drain();
    check("rand_err", 32'(err_cnt), 32'(err_exp));
    rand_ready = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
